// File: rtl/generic_rom_arb_pkg.sv
// Shared types and helpers for the ROM request arbiter.
// Holds the two-state FSM encoding and a round-robin winner search function.
// Combinational only; no latency, no backpressure.
package generic_rom_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Upper bound on requesters supported by the winner search.
  localparam int RR_MAX_REQ = 16;

  // Returns the first set request at or after ptr, wrapping at n_req.
  // Result is 0 when no request is set; callers qualify with |req.
  function automatic logic [3:0] rr_winner(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [3:0]            ptr,
    input int                    n_req
  );
    logic [4:0] idx;
    logic       found;
    rr_winner = '0;
    found     = 1'b0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      // ptr < n_req and k < n_req, so a single subtraction wraps correctly
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(n_req)) begin
        idx = idx - 5'(n_req);
      end
      if ((k < n_req) && !found && req[idx[3:0]]) begin
        rr_winner = idx[3:0];
        found     = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/generic_rom_rr_arbiter.sv
// Combinational round-robin winner select over the request vector.
// Ports: i_req (request vector), i_ptr (search start), o_winner (index), o_any (some request set).
// Zero latency; no backpressure, the pointer itself lives in the parent.
module generic_rom_rr_arbiter
  import generic_rom_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [$clog2(N_REQ)-1:0] o_winner,
  output logic                     o_any
);

  localparam int PW = $clog2(N_REQ);

  logic [RR_MAX_REQ-1:0] w_req_ext;
  logic [3:0]            w_ptr_ext;

  assign w_req_ext = RR_MAX_REQ'(i_req);
  assign w_ptr_ext = 4'(i_ptr);
  assign o_winner  = PW'(rr_winner(w_req_ext, w_ptr_ext, N_REQ));
  assign o_any     = |i_req;

endmodule

// File: rtl/generic_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM among N_REQ burst requesters.
// Grant/address same cycle as request; response one cycle after each beat (ROM latency).
// Requesters are held off via o_req_ready; responses cannot be back-pressured.
//
// Ports:
//   i_clk, i_rstn               clock, async active-low reset
//   i_req_valid/addr/len        per-requester burst request (len = words - 1)
//   o_req_ready                 one-hot acceptance pulse
//   o_rom_address, o_rom_issue  ROM address and live-beat flag
//   i_rom_read_data             ROM read data (registered, one cycle after address)
//   o_rsp_valid/data/last       one-hot routed response word, last-of-burst flag
//   o_busy                      burst streaming in progress
module generic_rom_arbiter
  import generic_rom_arb_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST     = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rstn,
  input  logic [N_REQ-1:0]                     i_req_valid,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0]       i_req_addr,
  input  logic [N_REQ*$clog2(MAX_BURST)-1:0]   i_req_len,
  output logic [N_REQ-1:0]                     o_req_ready,
  output logic [ADDRESS_WIDTH-1:0]             o_rom_address,
  output logic                                 o_rom_issue,
  input  logic [DATA_WIDTH-1:0]                i_rom_read_data,
  output logic [N_REQ-1:0]                     o_rsp_valid,
  output logic [DATA_WIDTH-1:0]                o_rsp_data,
  output logic                                 o_rsp_last,
  output logic                                 o_busy
);

  localparam int LW = $clog2(MAX_BURST);
  localparam int PW = $clog2(N_REQ);

  // FSM and burst context
  arb_state_t               r_state;
  arb_state_t               w_next_state;
  logic [PW-1:0]            r_ptr;
  logic [LW-1:0]            r_remaining;
  logic [ADDRESS_WIDTH-1:0] r_next_addr;
  logic [PW-1:0]            r_owner;
  logic [ADDRESS_WIDTH-1:0] r_rom_address;

  // Response tracking stage, aligned with the ROM's read latency
  logic                     r_rsp_vld;
  logic [PW-1:0]            r_rsp_idx;
  logic                     r_rsp_last;

  // Arbitration and issue signals
  logic [PW-1:0]            w_winner;
  logic                     w_any;
  logic [ADDRESS_WIDTH-1:0] w_win_addr;
  logic [LW-1:0]            w_win_len;
  logic                     w_grant;
  logic                     w_burst_last;
  logic                     w_issue;
  logic [ADDRESS_WIDTH-1:0] w_issue_addr;
  logic [PW-1:0]            w_issue_idx;
  logic                     w_issue_last;

  generic_rom_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_req    (i_req_valid),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_win_addr   = i_req_addr[w_winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign w_win_len    = i_req_len[w_winner*LW +: LW];
  // Reset gates the grant so nothing is acknowledged while reset is held,
  // even though the request inputs feed the outputs combinationally.
  assign w_grant      = (r_state == IDLE) && w_any && i_rstn;
  assign w_burst_last = (r_remaining == LW'(1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant && (w_win_len != '0)) w_next_state = BURST;
      BURST:   if (w_burst_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_req_ready  = '0;
    w_issue      = 1'b0;
    w_issue_addr = r_next_addr;
    w_issue_idx  = r_owner;
    w_issue_last = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          o_req_ready[w_winner] = 1'b1;
          w_issue               = 1'b1;
          w_issue_addr          = w_win_addr;
          w_issue_idx           = w_winner;
          w_issue_last          = (w_win_len == '0);
        end
      end
      BURST: begin
        // No arbitration here, including on the final beat
        w_issue      = 1'b1;
        w_issue_last = w_burst_last;
      end
      default: ;
    endcase
  end

  assign o_rom_issue   = w_issue;
  assign o_rom_address = w_issue ? w_issue_addr : r_rom_address;
  assign o_busy        = (r_state == BURST);

  // ---------------- burst context and pointer ----------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ptr         <= '0;
      r_remaining   <= '0;
      r_next_addr   <= '0;
      r_owner       <= '0;
      r_rom_address <= '0;
    end else begin
      if (w_issue) begin
        r_rom_address <= w_issue_addr;
      end
      if (w_grant) begin
        r_ptr       <= (w_winner == PW'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
        r_remaining <= w_win_len;
        // Address arithmetic wraps naturally at the bus width
        r_next_addr <= w_win_addr + 1'b1;
        r_owner     <= w_winner;
      end else if (r_state == BURST) begin
        r_remaining <= r_remaining - 1'b1;
        r_next_addr <= r_next_addr + 1'b1;
      end
    end
  end

  // ---------------- response stage ----------------
  // Reset clears this stage, so a beat issued just before reset never responds.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_idx  <= '0;
      r_rsp_last <= 1'b0;
    end else begin
      r_rsp_vld  <= w_issue;
      r_rsp_idx  <= w_issue_idx;
      r_rsp_last <= w_issue_last;
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (r_rsp_vld) begin
      o_rsp_valid[r_rsp_idx] = 1'b1;
    end
  end

  assign o_rsp_last = r_rsp_vld & r_rsp_last;
  assign o_rsp_data = i_rom_read_data;

endmodule

// File: tb/tb_generic_rom_arbiter.sv
// Self-checking bench for generic_rom_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level model of grants and responses.
// ROM is modelled in the bench as a one-cycle registered read with data = address.
module tb_generic_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic [N-1:0]    req_vld;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_rdy;
  logic [AW-1:0]   rom_addr;
  logic            rom_issue;
  logic [DW-1:0]   rom_q;
  logic [N-1:0]    rsp_vld;
  logic [DW-1:0]   rsp_dat;
  logic            rsp_last;
  logic            busy;

  generic_rom_arbiter #(.N_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) u_dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid(req_vld), .i_req_addr(req_addr), .i_req_len(req_len),
    .o_req_ready(req_rdy), .o_rom_address(rom_addr), .o_rom_issue(rom_issue),
    .i_rom_read_data(rom_q), .o_rsp_valid(rsp_vld), .o_rsp_data(rsp_dat),
    .o_rsp_last(rsp_last), .o_busy(busy)
  );

  always @(posedge clk) rom_q <= rom_addr;

  // narrow-address DUT for the wrap scenario
  logic [N-1:0]   req8_vld;
  logic [N*8-1:0] req8_addr;
  logic [N*LW-1:0] req8_len;
  logic [N-1:0]   req8_rdy;
  logic [7:0]     rom8_addr;
  logic           rom8_issue;
  logic [7:0]     rom8_q;
  logic [N-1:0]   rsp8_vld;
  logic [7:0]     rsp8_dat;
  logic           rsp8_last;
  logic           busy8;

  generic_rom_arbiter #(.N_REQ(N), .ADDRESS_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(MB)) u_dut8 (
    .i_clk(clk), .i_rstn(rstn),
    .i_req_valid(req8_vld), .i_req_addr(req8_addr), .i_req_len(req8_len),
    .o_req_ready(req8_rdy), .o_rom_address(rom8_addr), .o_rom_issue(rom8_issue),
    .i_rom_read_data(rom8_q), .o_rsp_valid(rsp8_vld), .o_rsp_data(rsp8_dat),
    .o_rsp_last(rsp8_last), .o_busy(busy8)
  );

  always @(posedge clk) rom8_q <= rom8_addr;

  int n_chk;
  int n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // requester side: each holds its request until the model says it was accepted
  bit            pend [N];
  logic [AW-1:0] paddr[N];
  logic [LW-1:0] plen [N];
  bit            rearm;
  bit            rand_mode;

  // transaction-level model
  int            m_ptr;
  int            m_left;
  logic [AW-1:0] m_addr;
  int            m_own;
  logic [AW-1:0] m_prev;
  bit            m_rsp_due;
  int            m_rsp_own;
  bit            m_rsp_last;
  logic [AW-1:0] m_rsp_addr;

  // per-cycle logs of observed outputs for directed scenarios
  logic [N-1:0]  log_rdy [$];
  logic [N-1:0]  log_rsp [$];
  bit            log_issue[$];
  bit            log_busy [$];
  bit            log_last [$];
  logic [AW-1:0] log_addr [$];

  task automatic log_clear();
    log_rdy.delete(); log_rsp.delete(); log_issue.delete();
    log_busy.delete(); log_last.delete(); log_addr.delete();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_left = 0; m_addr = '0; m_own = 0; m_prev = '0;
    m_rsp_due = 0; m_rsp_own = 0; m_rsp_last = 0; m_rsp_addr = '0;
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < N; n++) begin
      req_vld[n]           = pend[n];
      req_addr[n*AW +: AW] = paddr[n];
      req_len[n*LW +: LW]  = plen[n];
    end
  endtask

  task automatic new_reqs();
    for (int n = 0; n < N; n++) begin
      if (!pend[n]) begin
        if ($urandom_range(0, 2) == 0) begin
          pend[n]  = 1;
          paddr[n] = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 4)))
                                                 : 32'($urandom);
          plen[n]  = ($urandom_range(0, 1) == 0) ? '0 : LW'($urandom_range(0, MB - 1));
        end else begin
          // idle requesters wiggle their payload; must not disturb anything
          paddr[n] = 32'($urandom);
          plen[n]  = LW'($urandom_range(0, MB - 1));
        end
      end
    end
  endtask

  // one clock: check outputs at the falling edge, advance model, update requesters
  task automatic run_cycle();
    logic [N-1:0]  e_rdy;
    logic [N-1:0]  e_rsp;
    logic          e_issue;
    logic          e_busy;
    logic          e_last;
    logic [AW-1:0] e_addr;
    int            w;
    @(negedge clk);
    e_rdy = '0; e_rsp = '0; e_issue = 0; e_addr = m_prev; w = -1;
    e_busy = (m_left > 0);
    if (m_rsp_due) e_rsp[m_rsp_own] = 1'b1;
    e_last = m_rsp_due && m_rsp_last;
    chk("rsp_vld", 64'(rsp_vld), 64'(e_rsp));
    chk("rsp_last", 64'(rsp_last), 64'(e_last));
    if (m_rsp_due) chk("rsp_dat", 64'(rsp_dat), 64'(m_rsp_addr));
    m_rsp_due = 0;
    if (m_left > 0) begin
      e_issue = 1; e_addr = m_addr;
      m_rsp_due = 1; m_rsp_own = m_own; m_rsp_last = (m_left == 1); m_rsp_addr = m_addr;
      m_addr = m_addr + 1;
      m_left--;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0) begin
        e_rdy[w] = 1'b1; e_issue = 1; e_addr = paddr[w];
        m_rsp_due = 1; m_rsp_own = w; m_rsp_last = (plen[w] == 0); m_rsp_addr = paddr[w];
        m_addr = paddr[w] + 1; m_left = int'(plen[w]); m_own = w;
        m_ptr = (w + 1) % N;
      end
    end
    m_prev = e_addr;
    chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
    chk("rom_issue", 64'(rom_issue), 64'(e_issue));
    chk("rom_addr", 64'(rom_addr), 64'(e_addr));
    chk("busy", 64'(busy), 64'(e_busy));
    log_rdy.push_back(req_rdy); log_rsp.push_back(rsp_vld); log_issue.push_back(rom_issue);
    log_busy.push_back(busy); log_last.push_back(rsp_last); log_addr.push_back(rom_addr);
    @(posedge clk);
    #1;
    if (w >= 0 && !rearm) pend[w] = 0;
    if (rand_mode) new_reqs();
    drive_inputs();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rdy"}, 64'(req_rdy), 64'd0);
    chk({tag, "_issue"}, 64'(rom_issue), 64'd0);
    chk({tag, "_addr"}, 64'(rom_addr), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp"}, 64'(rsp_vld), 64'd0);
    chk({tag, "_last"}, 64'(rsp_last), 64'd0);
  endtask

  // called at posedge+#1; holds reset across two falling edges
  task automatic reset_seq(input string tag);
    rstn = 1'b0;
    @(negedge clk);
    chk_zero_outputs(tag);
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero_outputs(tag);
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    drive_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_iss, n_busy, n_rsp, last_at;
    logic [7:0] exp8 [4];
    n_chk = 0; n_bad = 0; rearm = 0; rand_mode = 0;
    for (int n = 0; n < N; n++) begin pend[n] = 0; paddr[n] = '0; plen[n] = '0; end
    req8_vld = '0; req8_addr = '0; req8_len = '0;
    model_reset();
    drive_inputs();
    @(posedge clk); #1;

    // requests 0 and 2, len 0, present through reset
    pend[0] = 1; paddr[0] = 32'h100; pend[2] = 1; paddr[2] = 32'h200;
    drive_inputs();
    reset_seq("rst");
    log_clear();
    repeat (4) run_cycle();
    chk("s39_rdy0", 64'(log_rdy[0]), 64'h1);
    chk("s39_rdy1", 64'(log_rdy[1]), 64'h4);
    chk("s39_rsp1", 64'(log_rsp[1]), 64'h1);
    chk("s39_rsp2", 64'(log_rsp[2]), 64'h4);
    chk("s39_last1", 64'(log_last[1]), 64'h1);

    // all four held valid with len 0
    reset_seq("rst2");
    rearm = 1;
    for (int n = 0; n < N; n++) begin pend[n] = 1; paddr[n] = 32'(n * 16); plen[n] = '0; end
    drive_inputs();
    log_clear();
    repeat (8) run_cycle();
    rearm = 0;
    for (int n = 0; n < N; n++) pend[n] = 0;
    drive_inputs();
    for (int i = 0; i < 8; i++) begin
      chk("s40_order", 64'(log_rdy[i]), 64'(1 << (i % 4)));
      chk("s40_issue", 64'(log_issue[i]), 64'h1);
    end
    repeat (2) run_cycle();

    // requester 1, addr 'h10, len 3
    pend[1] = 1; paddr[1] = 32'h10; plen[1] = 3'd3;
    drive_inputs();
    log_clear();
    repeat (6) run_cycle();
    n_iss = 0; n_busy = 0; n_rsp = 0; last_at = -1;
    for (int i = 0; i < 6; i++) begin
      if (log_issue[i]) begin
        chk("s41_addr", 64'(log_addr[i]), 64'(32'h10 + 32'(n_iss)));
        n_iss++;
      end
      if (log_busy[i]) n_busy++;
      if (log_rsp[i] != '0) begin
        chk("s41_rsp_route", 64'(log_rsp[i]), 64'h2);
        n_rsp++;
        if (log_last[i]) last_at = n_rsp;
      end
    end
    chk("s41_beats", 64'(n_iss), 64'd4);
    chk("s41_busy_cycles", 64'(n_busy), 64'd3);
    chk("s41_rsps", 64'(n_rsp), 64'd4);
    chk("s41_last_pos", 64'(last_at), 64'd4);
    chk("s41_idle_after", 64'(log_issue[4]), 64'd0);

    // 8-bit address wrap on the narrow instance
    exp8[0] = 8'hFE; exp8[1] = 8'hFF; exp8[2] = 8'h00; exp8[3] = 8'h01;
    req8_vld = 4'b0001; req8_addr[7:0] = 8'hFE; req8_len[2:0] = 3'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s42_addr", 64'(rom8_addr), 64'(exp8[i]));
      chk("s42_issue", 64'(rom8_issue), 64'd1);
      @(posedge clk); #1;
      req8_vld = '0; req8_addr = '1; req8_len = '1;
    end
    @(negedge clk);
    chk("s42_last_rsp", 64'({rsp8_vld, rsp8_last}), 64'({4'b0001, 1'b1}));
    chk("s42_last_dat", 64'(rsp8_dat), 64'h01);
    chk("s42_idle", 64'(rom8_issue), 64'd0);
    @(posedge clk); #1;

    // reset on the second beat of a len 7 burst
    pend[0] = 1; paddr[0] = 32'h40; plen[0] = 3'd7;
    drive_inputs();
    run_cycle();
    pend[1] = 1; paddr[1] = 32'h80; plen[1] = '0;
    drive_inputs();
    reset_seq("s43_rst");
    log_clear();
    repeat (3) run_cycle();
    chk("s43_no_stale_rsp", 64'(log_rsp[0]), 64'd0);
    chk("s43_regrant", 64'(log_rdy[0]), 64'h2);

    // random multi-requester traffic
    rand_mode = 1;
    repeat (800) run_cycle();
    rand_mode = 0;
    for (int n = 0; n < N; n++) pend[n] = 0;
    drive_inputs();
    repeat (12) run_cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
